// File: rtl/wb_gpio_irq_pkg.sv
// Shared definitions for the Wishbone GPIO block with edge interrupts.
// Contents: register word indices, register index width and bus data width.
package wb_gpio_irq_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] REG_OUT     = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_DIR     = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_IN      = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_RISE_EN = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_FALL_EN = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_STATUS  = 3'd5;
  localparam logic [REG_IDX_W-1:0] REG_SET     = 3'd6;
  localparam logic [REG_IDX_W-1:0] REG_CLR     = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser and edge detector for a WIDTH-bit pin vector.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   pin       : asynchronous pin inputs
//   in_sync   : pins after SYNC_STAGES flops
//   rise/fall : single-cycle edge pulses, held low during warm-up
module gpio_sync_edge #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] warm_cnt;
  logic             warm;

  // The chain and prev are zeroed by reset, so a high pin would look like a
  // rising edge while the chain fills; edges are ignored until the counter
  // has seen the chain and prev fully refreshed.
  assign warm    = (warm_cnt == WARM_MAX);
  assign in_sync = sync_q[SYNC_STAGES-1];
  assign rise    = warm ? (in_sync & ~prev_q) : '0;
  assign fall    = warm ? (~in_sync & prev_q) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q   <= '0;
      warm_cnt <= '0;
    end else begin
      sync_q[0] <= pin;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= in_sync;
      if (!warm) warm_cnt <= warm_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone B3 classic slave GPIO with per-pin direction, synchronised
// inputs, rise/fall edge interrupts (W1C status) and atomic set/clear.
// Ports:
//   wb_clk, wb_rst          : clock, synchronous active-high reset
//   wb_adr_i .. wb_bte_i    : Wishbone slave inputs (cti/bte ignored)
//   wb_dat_o, wb_ack_o      : registered read data and single-cycle ack
//   wb_err_o, wb_rty_o      : tied low
//   gpio_i                  : asynchronous pin inputs
//   gpio_o, gpio_oe         : OUT and DIR registers
//   irq_o                   : registered OR of STATUS
module wb_gpio_irq
  import wb_gpio_irq_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [2:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_o
);

  logic [WIDTH-1:0]  rise_en_q, fall_en_q, status_q, status_next;
  logic [WIDTH-1:0]  in_sync, rise, fall;
  logic [WIDTH-1:0]  wmask, wdat, w1c;
  logic [DATA_W-1:0] bmask, rd_data;
  logic              access, wr;
  logic              unused_bits;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (wb_clk),
    .rst     (wb_rst),
    .pin     (gpio_i),
    .in_sync (in_sync),
    .rise    (rise),
    .fall    (fall)
  );

  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;
  assign unused_bits = ^{wb_cti_i, wb_bte_i, wb_dat_i, bmask};

  // ~ack gives the 1-cycle ack with a 1-cycle gap when stb is held.
  assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr     = access & wb_we_i;

  assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                  {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wmask = bmask[WIDTH-1:0];
  // Masked data: used directly by SET/CLR/W1C so disabled lanes are inert.
  assign wdat  = wb_dat_i[WIDTH-1:0] & wmask;
  assign w1c   = (wr && wb_adr_i == REG_STATUS) ? wdat : '0;

  // New events win over a simultaneous W1C.
  assign status_next = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      REG_OUT:     rd_data[WIDTH-1:0] = gpio_o;
      REG_DIR:     rd_data[WIDTH-1:0] = gpio_oe;
      REG_IN:      rd_data[WIDTH-1:0] = in_sync;
      REG_RISE_EN: rd_data[WIDTH-1:0] = rise_en_q;
      REG_FALL_EN: rd_data[WIDTH-1:0] = fall_en_q;
      REG_STATUS:  rd_data[WIDTH-1:0] = status_q;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      gpio_o    <= OUT_RESET;
      gpio_oe   <= DIR_RESET;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      irq_o     <= 1'b0;
    end else begin
      wb_ack_o <= access;
      if (access) wb_dat_o <= rd_data;
      status_q <= status_next;
      irq_o    <= |status_next;
      if (wr) begin
        case (wb_adr_i)
          REG_OUT:     gpio_o    <= (gpio_o    & ~wmask) | wdat;
          REG_DIR:     gpio_oe   <= (gpio_oe   & ~wmask) | wdat;
          REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wdat;
          REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wdat;
          REG_SET:     gpio_o    <= gpio_o | wdat;
          REG_CLR:     gpio_o    <= gpio_o & ~wdat;
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq (WIDTH=8, SYNC_STAGES=2).
module tb_wb_gpio_irq;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o;
  logic        ack, err, rty;
  logic [7:0]  gpio_i, gpio_o, gpio_oe;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  wb_gpio_irq #(
    .WIDTH       (8),
    .SYNC_STAGES (SYNC),
    .OUT_RESET   (8'h00),
    .DIR_RESET   (8'hFF)
  ) dut (
    .wb_clk   (clk),
    .wb_rst   (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty),
    .gpio_i   (gpio_i),
    .gpio_o   (gpio_o),
    .gpio_oe  (gpio_oe),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic [7:0]  exp_gpo;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  logic [7:0] m_out, m_dir, m_re, m_fe, m_st, m_pins;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after an edge; returns #1 after the ack edge.
  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got = 1'b1;
        rd  = dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL bus_timeout: got no ack expected ack within 8 cycles (adr %0d)", a);
    end
  endtask

  task automatic add(input logic w, input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] er, input logic [7:0] eg);
    vec_t v;
    v.we = w; v.adr = a; v.dat = d; v.sel = s; v.exp_rd = er; v.exp_gpo = eg;
    tbl.push_back(v);
  endtask

  function automatic logic [7:0] lane0(input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return m[7:0];
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, m_out};
      3'd1:    return {24'h0, m_dir};
      3'd2:    return {24'h0, m_pins};
      3'd3:    return {24'h0, m_re};
      3'd4:    return {24'h0, m_fe};
      3'd5:    return {24'h0, m_st};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [7:0] m, v;
    m = lane0(s);
    v = d[7:0] & m;
    case (a)
      3'd0: m_out = (m_out & ~m) | v;
      3'd1: m_dir = (m_dir & ~m) | v;
      3'd3: m_re  = (m_re & ~m) | v;
      3'd4: m_fe  = (m_fe & ~m) | v;
      3'd5: m_st  = m_st & ~v;
      3'd6: m_out = m_out | v;
      3'd7: m_out = m_out & ~v;
      default: ;
    endcase
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  newp;
    int          op;
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    rst = 1'b1; adr = '0; dat_i = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    cti = '0; bte = '0; gpio_i = 8'h3C;

    // Reset values
    tick(3);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat_o", dat_o, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_gpio_o", {24'h0, gpio_o}, 32'h00);
    chk("rst_gpio_oe", {24'h0, gpio_oe}, 32'hFF);
    chk("rst_err_rty", {30'h0, err, rty}, 32'h0);
    rst = 1'b0;
    tick(4);

    // Register map table
    add(0, 3'd0, 0, 4'hF, 32'h00, 8'h00);
    add(0, 3'd1, 0, 4'hF, 32'hFF, 8'h00);
    add(0, 3'd2, 0, 4'hF, 32'h3C, 8'h00);
    add(0, 3'd3, 0, 4'hF, 32'h00, 8'h00);
    add(0, 3'd4, 0, 4'hF, 32'h00, 8'h00);
    add(0, 3'd5, 0, 4'hF, 32'h00, 8'h00);
    add(0, 3'd6, 0, 4'hF, 32'h00, 8'h00);
    add(0, 3'd7, 0, 4'hF, 32'h00, 8'h00);
    add(1, 3'd0, 32'hA5, 4'hF, 0, 8'hA5);
    add(1, 3'd6, 32'h0F, 4'hF, 0, 8'hAF);
    add(1, 3'd7, 32'h81, 4'hF, 0, 8'h2E);
    add(0, 3'd0, 0, 4'hF, 32'h2E, 8'h2E);
    add(1, 3'd0, 32'h12345678, 4'h1, 0, 8'h78);
    add(1, 3'd0, 32'h000000FF, 4'h2, 0, 8'h78);
    add(1, 3'd6, 32'hFF, 4'h2, 0, 8'h78);
    add(1, 3'd7, 32'hFF, 4'hE, 0, 8'h78);
    add(1, 3'd1, 32'h0F, 4'hF, 0, 8'h78);
    add(0, 3'd1, 0, 4'hF, 32'h0F, 8'h78);
    add(1, 3'd2, 32'hFF, 4'hF, 0, 8'h78);
    add(0, 3'd2, 0, 4'hF, 32'h3C, 8'h78);
    add(1, 3'd1, 32'hFFFFFFFF, 4'hF, 0, 8'h78);
    add(0, 3'd1, 0, 4'hF, 32'hFF, 8'h78);
    add(1, 3'd3, 32'h1FF, 4'hF, 0, 8'h78);
    add(0, 3'd3, 0, 4'hF, 32'hFF, 8'h78);
    add(1, 3'd3, 32'h0, 4'hF, 0, 8'h78);
    add(0, 3'd6, 0, 4'hF, 32'h00, 8'h78);
    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
      if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_gpio_o", i), {24'h0, gpio_o}, {24'h0, tbl[i].exp_gpo});
    end
    chk("gpio_oe_after_dir", {24'h0, gpio_oe}, 32'hFF);

    // Ack timing with stb held
    tick(1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd0;
    chk("ack_t0", {31'h0, ack}, 32'h0);
    tick(1);
    chk("ack_t1", {31'h0, ack}, 32'h1);
    tick(1);
    chk("ack_t2", {31'h0, ack}, 32'h0);
    tick(1);
    chk("ack_t3", {31'h0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0;
    tick(1);
    chk("ack_idle", {31'h0, ack}, 32'h0);

    // Edge interrupts and W1C
    gpio_i = 8'h02;
    tick(6);
    bus(1, 3'd3, 32'h01, 4'hF, rd);
    bus(1, 3'd4, 32'h02, 4'hF, rd);
    bus(1, 3'd5, 32'hFF, 4'hF, rd);
    tick(1);
    gpio_i = 8'h01;
    tick(SYNC);
    chk("irq_before_edge", {31'h0, irq}, 32'h0);
    tick(1);
    chk("irq_edge", {31'h0, irq}, 32'h1);
    bus(0, 3'd5, 0, 4'hF, rd);
    chk("status_03", rd, 32'h03);
    bus(1, 3'd5, 32'h01, 4'hF, rd);
    bus(0, 3'd5, 0, 4'hF, rd);
    chk("status_02", rd, 32'h02);
    chk("irq_still", {31'h0, irq}, 32'h1);
    bus(1, 3'd5, 32'h02, 4'hF, rd);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    bus(1, 3'd5, 32'h01, 4'hE, rd);

    // New rising edge on the same edge as its W1C: set wins
    gpio_i = 8'h00;
    tick(6);
    gpio_i = 8'h01;
    tick(6);
    bus(0, 3'd5, 0, 4'hF, rd);
    chk("status_pre_setwin", rd, 32'h01);
    gpio_i = 8'h00;
    tick(6);
    gpio_i = 8'h01;
    tick(SYNC);
    bus(1, 3'd5, 32'h01, 4'hF, rd);
    bus(0, 3'd5, 0, 4'hF, rd);
    chk("status_setwin", rd, 32'h01);
    chk("irq_setwin", {31'h0, irq}, 32'h1);

    // Warm-up suppression
    gpio_i = 8'hFF;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    bus(1, 3'd3, 32'hFF, 4'hF, rd);
    tick(6);
    chk("warm_irq", {31'h0, irq}, 32'h0);
    bus(0, 3'd5, 0, 4'hF, rd);
    chk("warm_status", rd, 32'h00);
    bus(0, 3'd3, 0, 4'hF, rd);
    chk("warm_rise_en", rd, 32'hFF);

    // Reset during an OUT write
    bus(1, 3'd0, 32'h5A, 4'hF, rd);
    chk("pre_rst_out", {24'h0, gpio_o}, 32'h5A);
    tick(1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd0; dat_i = 32'hC3; sel = 4'hF;
    rst = 1'b1;
    tick(1);
    chk("midrst_ack", {31'h0, ack}, 32'h0);
    chk("midrst_out", {24'h0, gpio_o}, 32'h00);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick(1);
    chk("midrst_ack2", {31'h0, ack}, 32'h0);
    chk("midrst_out2", {24'h0, gpio_o}, 32'h00);

    // Randomised phase against the transaction-level model
    tick(6);
    m_out = 8'h00; m_dir = 8'hFF; m_re = 8'h00; m_fe = 8'h00; m_st = 8'h00;
    m_pins = gpio_i;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      if (op < 2) begin
        newp = 8'($urandom);
        gpio_i = newp;
        tick(SYNC + 3);
        m_st = m_st | ((newp & ~m_pins) & m_re) | ((~newp & m_pins) & m_fe);
        m_pins = newp;
        chk("rnd_irq_pin", {31'h0, irq}, {31'h0, |m_st});
      end else if (op < 6) begin
        a = 3'($urandom_range(0, 7));
        d = $urandom;
        s = 4'($urandom);
        bus(1, a, d, s, rd);
        model_write(a, d, s);
        chk("rnd_gpio_o", {24'h0, gpio_o}, {24'h0, m_out});
        chk("rnd_gpio_oe", {24'h0, gpio_oe}, {24'h0, m_dir});
        chk("rnd_irq_wr", {31'h0, irq}, {31'h0, |m_st});
      end else begin
        a = 3'($urandom_range(0, 7));
        bus(0, a, 0, 4'($urandom), rd);
        chk($sformatf("rnd_rd_%0d", a), rd, model_read(a));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
